// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Counter width able to hold step indices 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
module div_step #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   rem,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_next,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] diff;
  logic       unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is never set.
  assign unused_rem_msb = rem[N];
  assign shifted        = {rem[N-1:0], q_msb};
  assign diff           = shifted - {1'b0, divisor};
  assign q_bit          = ~diff[N];
  assign rem_next       = q_bit ? diff : shifted;

endmodule

// File: rtl/div_param_seq.sv
// Multi-cycle radix-2 restoring divider with valid/ready handshakes, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement (truncating) division; default build is unsigned.
module div_param_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  import div_pkg::*;

  localparam int unsigned CW = cnt_width(N);

  div_state_t    state;
  div_state_t    state_n;
  logic [N-1:0]  q_sr;
  logic [N-1:0]  dvsr;
  logic [N:0]    r_sr;
  logic [N:0]    r_nx;
  logic [N-1:0]  q_nx;
  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_r;
  logic [CW-1:0] cnt;
  logic          zero_pend;
  logic          q_bit;
  logic          last;
  logic          accept;

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(N - 1));
  assign q_nx   = {q_sr[N-2:0], q_bit};

  div_step #(.N(N)) u_step (
    .rem      (r_sr),
    .q_msb    (q_sr[N-1]),
    .divisor  (dvsr),
    .rem_next (r_nx),
    .q_bit    (q_bit)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign mag_a = dividend[N-1] ? N'(-dividend) : dividend;
  assign mag_b = divisor[N-1]  ? N'(-divisor)  : divisor;
  // Most-negative / -1 yields a magnitude of 2^(N-1) with no negation, which wraps to most-negative.
  assign res_q = neg_q ? N'(-q_nx) : q_nx;
  assign res_r = neg_r ? N'(-r_nx[N-1:0]) : r_nx[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[N-1] ^ divisor[N-1];
      neg_r <= dividend[N-1];
    end
  end
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign res_q = q_nx;
  assign res_r = r_nx[N-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a zero divisor spends a single cycle in CALC before DONE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CALC;
      CALC:    if (zero_pend || last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_sr        <= '0;
      dvsr        <= '0;
      r_sr        <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (accept) begin
        q_sr      <= mag_a;
        dvsr      <= mag_b;
        r_sr      <= '0;
        cnt       <= '0;
        zero_pend <= (divisor == '0);
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC && !zero_pend) begin
        q_sr <= q_nx;
        r_sr <= r_nx;
        cnt  <= cnt + CW'(1);
        if (last) begin
          quotient    <= res_q;
          remainder   <= res_r;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_param_seq.sv
// Self-checking bench for div_param_seq at N=8: vector table, handshake corner sequences, random vs model.
module tb_div_param_seq;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t tbl[$];

  div_param_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands as the user sees them.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic z);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    z  = (b == 8'd0);
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
    end
`ifdef DIV_SIGNED_EN
    else if (sa == -128 && sb == -1) begin
      q = 8'h80;
      r = 8'h00;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: out_valid never rose", tag);
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready rise"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic ez, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (b == 8'd0) ? 1 : int'(N);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    release_result(tag);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
    int         lat;

`ifdef DIV_SIGNED_EN
    tbl.push_back(vec_t'{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});
    tbl.push_back(vec_t'{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
    tbl.push_back(vec_t'{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
    tbl.push_back(vec_t'{8'd37, 8'd0, 8'hFF, 8'd37, 1'b1});
    tbl.push_back(vec_t'{8'd0, 8'd3, 8'd0, 8'd0, 1'b0});
    tbl.push_back(vec_t'{8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0});
    tbl.push_back(vec_t'{8'h80, 8'd1, 8'h80, 8'd0, 1'b0});
`else
    tbl.push_back(vec_t'{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
    tbl.push_back(vec_t'{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
    tbl.push_back(vec_t'{8'd5, 8'd9, 8'd0, 8'd5, 1'b0});
    tbl.push_back(vec_t'{8'd0, 8'd3, 8'd0, 8'd0, 1'b0});
    tbl.push_back(vec_t'{8'd37, 8'd0, 8'd255, 8'd37, 1'b1});
    tbl.push_back(vec_t'{8'd9, 8'd4, 8'd2, 8'd1, 1'b0});
    tbl.push_back(vec_t'{8'd255, 8'd255, 8'd1, 8'd0, 1'b0});
    tbl.push_back(vec_t'{8'd254, 8'd255, 8'd0, 8'd254, 1'b0});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, $sformatf("vec%0d", i));

    // Backpressure: result must hold while new operands are offered and ignored
    ref_div(8'd200, 8'd13, eq, er, ez);
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd13;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("bp", lat);
    check("bp latency", 32'(lat), 32'(N));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp hold q %0d", k), 32'(quotient), 32'(eq));
      check($sformatf("bp hold r %0d", k), 32'(remainder), 32'(er));
      check($sformatf("bp out_valid %0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp in_ready %0d", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("bp");

    // Reset while CALC has taken three steps
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("midrst no output", 32'(out_valid), 32'd0);
    ref_div(8'd9, 8'd4, eq, er, ez);
    run_op(8'd9, 8'd4, eq, er, ez, "post_rst");

    // Random operands against the arithmetic model, with some zero divisors
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      ref_div(a, b, eq, er, ez);
      run_op(a, b, eq, er, ez, $sformatf("rnd%0d %0d/%0d", n, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
